tcp_tx_scheduler: RTL
=====================

Name: tcp_tx_scheduler

Overview:
Shares the single TCP/IP transmit engine between several segment sources: TCP control segments, TCP data segments, ARP replies and ICMP echo replies. Latches one-cycle request pulses and arbitrates: req 0 has strict priority, the others are served round-robin. Sequences the engine with a start pulse, waits for end-of-write, then enforces an inter-packet gap. A watchdog recovers if the engine never reports completion.

Parameters:
NUM_REQ, 4, number of requesters (2..8); index 0 is the strict-priority source (TCP control).
IFG_CYCLES, 12, idle cycles inserted after each packet before the next grant (0 = no gap).
TIMEOUT_CYCLES, 65535, maximum cycles waiting for op_end_i before abort (1..65535; counter is 16 bits).

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req_i  in  NUM_REQ  one-cycle request pulse per source
flush_i  in  1  clear all pending requests
trnsmt_busy_i  in  1  transmit engine/MAC busy; no grant while high
tcp_write_op_end_i  in  1  engine finished current packet (pulse)
start_o  out  1  one-cycle start pulse to the engine
grant_o  out  NUM_REQ  one-hot; held from start_o until the packet ends
sel_o  out  clog2(NUM_REQ)  index of the granted source; valid while grant_o != 0
pend_o  out  NUM_REQ  pending request bits
idle_o  out  1  high in IDLE state
timeout_o  out  1  one-cycle pulse on watchdog abort
merge_cnt_o  out  8  saturating count of requests merged into an already-pending bit

Behaviour:
- Reset (async, rst_n low): state IDLE; pend_o, grant_o, sel_o, start_o, timeout_o = 0; merge_cnt_o = 0; idle_o = 1; round-robin pointer = 1.
- Pending: req_i[k] sets pend[k] at the next edge.
  - If req_i[k] arrives while pend[k] is already 1: merge_cnt_o increments, saturating at 255.
  - Clear on grant. If req_i[k] coincides with the grant of k, pend[k] stays 1 and no merge is counted.
  - flush_i clears all pend bits except those set by a same-cycle req_i, which win. flush_i does not alter state or grant.
- States: IDLE, START, WAIT_END, GAP.
  - IDLE: if pend != 0 and !trnsmt_busy_i, choose a winner and go to START.
  - Winner selection: pend[0] wins if set. Otherwise the first set bit at or after the RR pointer among 1..NUM_REQ-1, wrapping from NUM_REQ-1 to 1. The pointer then becomes winner+1, wrapping to 1. The pointer is unchanged when index 0 wins.
  - START (one cycle): start_o = 1, grant_o/sel_o = winner, pend[winner] cleared. Next state is WAIT_END.
  - WAIT_END: hold grant, watchdog counts up from 0.
    - tcp_write_op_end_i = 1 -> go to GAP (or IDLE if IFG_CYCLES = 0), drop grant_o.
    - Counter reaches TIMEOUT_CYCLES-1 with no op_end -> timeout_o pulse, same exit as op_end.
    - op_end and timeout in the same cycle: op_end wins, no timeout pulse.
  - GAP: counts IFG_CYCLES cycles, then IDLE. No grant is issued during GAP.
- Latency: req_i at edge t -> pend at t+1 -> START (start_o high) at t+2 when idle and not busy. Back-to-back packets are separated by at least IFG_CYCLES+1 idle cycles after op_end.
- tcp_write_op_end_i outside WAIT_END is ignored.
- trnsmt_busy_i is sampled only in IDLE; changes after START have no effect.
- Reset mid-packet: everything returns to reset values immediately; in-flight requests are lost.

Decomposition:
- Package tcp_tx_sched_pkg: state encoding (one-hot 4-bit localparams ST_IDLE/ST_START/ST_WAIT_END/ST_GAP), requester index constants (REQ_TCP_CTRL=0, REQ_TCP_DATA=1, REQ_ARP=2, REQ_ICMP=3), watchdog counter width 16.
- Sub-module rr_pick: combinational priority-plus-round-robin picker. Inputs are pend and the pointer; outputs are a one-hot winner, its index, and a valid flag.

Test Plan:
- Single request: pulse req_i=4'b0010 at t -> start_o at t+2, grant_o=0010, sel_o=1. op_end 5 cycles later -> grant_o=0; next start_o no earlier than 13 cycles after op_end.
- Priority and round-robin: with the engine stalled busy, set pend=1110 then pend[0]. Release busy -> grant order 0, 1, 2, 3 (each after op_end + gap). Then pend=1010 with pointer=2 -> grant 3, then 1.
- Busy hold-off: pend=0001, trnsmt_busy_i held high for 20 cycles -> no start_o; start_o exactly 1 cycle after busy falls.
- Merge/coincidence: pulse req_i[1] twice while pending -> merge_cnt_o=1. Pulse req_i[1] in the START cycle for index 1 -> pend[1]=1 afterwards, merge_cnt_o unchanged. Apply 300 merges -> merge_cnt_o=255.
- Watchdog: TIMEOUT_CYCLES=100, no op_end -> timeout_o pulse 100 cycles after START, grant dropped, the next pending request is served after the gap. op_end on that same cycle instead -> no timeout_o.
- Flush/reset: pend=1111, flush_i together with req_i[2] -> pend=0100. rst_n low during WAIT_END -> all outputs at reset values asynchronously, idle_o=1.

Source files
------------

// File: rtl/tcp_tx_scheduler_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : tcp_tx_sched_pkg                                                 |
// | Purpose : Shared types and constants for the TCP/IP transmit scheduler:    |
// |           FSM state encoding, requester indices, watchdog width and a      |
// |           saturating add used by the merge counter.                        |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package tcp_tx_sched_pkg;

  localparam int STATE_W = 4;

  // One-hot state encoding.
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE     = 4'b0001,
    ST_START    = 4'b0010,
    ST_WAIT_END = 4'b0100,
    ST_GAP      = 4'b1000
  } state_t;

  // Requester slots; slot 0 is the strict-priority source.
  localparam int REQ_TCP_CTRL = 0;
  localparam int REQ_TCP_DATA = 1;
  localparam int REQ_ARP      = 2;
  localparam int REQ_ICMP     = 3;

  // Shared watchdog / inter-frame-gap counter width.
  localparam int WDOG_W  = 16;
  localparam int MERGE_W = 8;

  // Adds a small increment to an 8-bit count, clamping at all-ones.
  function automatic logic [MERGE_W-1:0] sat_add8(input logic [MERGE_W-1:0] a,
                                                  input logic [3:0]         b);
    logic [MERGE_W:0] sum;
    sum = {1'b0, a} + {5'b00000, b};
    return sum[MERGE_W] ? {MERGE_W{1'b1}} : sum[MERGE_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/tcp_tx_scheduler_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : tcp_tx_scheduler_if                                            |
// | Purpose   : Bundles the request side and engine handshake of the transmit  |
// |             scheduler.                                                     |
// | Ports     : req_i/flush_i        - request pulses, pending flush           |
// |             trnsmt_busy_i         - engine busy, blocks new grants         |
// |             tcp_write_op_end_i    - engine packet-complete pulse           |
// |             start_o/grant_o/sel_o - engine start pulse, one-hot grant, idx |
// |             pend_o/idle_o         - pending bits, scheduler idle           |
// |             timeout_o/merge_cnt_o - watchdog abort pulse, merge counter    |
// |             modport master drives the inputs, modport slave is the sched.  |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
interface tcp_tx_scheduler_if #(
  parameter int NUM_REQ = 4
);
  localparam int c_sel_w = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] req_i;
  logic               flush_i;
  logic               trnsmt_busy_i;
  logic               tcp_write_op_end_i;
  logic               start_o;
  logic [NUM_REQ-1:0] grant_o;
  logic [c_sel_w-1:0] sel_o;
  logic [NUM_REQ-1:0] pend_o;
  logic               idle_o;
  logic               timeout_o;
  logic [7:0]         merge_cnt_o;

  modport master (
    output req_i, flush_i, trnsmt_busy_i, tcp_write_op_end_i,
    input  start_o, grant_o, sel_o, pend_o, idle_o, timeout_o, merge_cnt_o
  );

  modport slave (
    input  req_i, flush_i, trnsmt_busy_i, tcp_write_op_end_i,
    output start_o, grant_o, sel_o, pend_o, idle_o, timeout_o, merge_cnt_o
  );
endinterface
`default_nettype wire

// File: rtl/tcp_tx_scheduler_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : rr_pick                                                          |
// | Purpose : Combinational winner selection. Slot 0 always wins when pending; |
// |           otherwise the first pending slot at or after the pointer among   |
// |           1..NUM_REQ-1, wrapping from NUM_REQ-1 back to 1.                 |
// | Ports   : i_pend    - pending request bits                                 |
// |           i_ptr     - round-robin pointer (1..NUM_REQ-1)                   |
// |           o_win_oh  - one-hot winner                                       |
// |           o_win_idx - winner index                                         |
// |           o_valid   - a winner exists                                      |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int SEL_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_pend,
  input  logic [SEL_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_win_oh,
  output logic [SEL_W-1:0]   o_win_idx,
  output logic               o_valid
);
  localparam int c_rr_n = NUM_REQ - 1;

  always_comb begin
    o_win_oh  = '0;
    o_win_idx = '0;
    o_valid   = 1'b0;
    if (i_pend[0]) begin
      o_win_oh[0] = 1'b1;
      o_valid     = 1'b1;
    end else begin
      // Offset i walks the RR ring starting at the pointer; first hit wins.
      for (int i = 0; i < c_rr_n; i++) begin
        if (!o_valid && i_pend[((int'(i_ptr) - 1 + i) % c_rr_n) + 1]) begin
          o_win_oh[((int'(i_ptr) - 1 + i) % c_rr_n) + 1] = 1'b1;
          o_win_idx = SEL_W'(((int'(i_ptr) - 1 + i) % c_rr_n) + 1);
          o_valid   = 1'b1;
        end
      end
    end
  end
endmodule
`default_nettype wire

// File: rtl/tcp_tx_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tcp_tx_scheduler                                                 |
// | Purpose : Shares one TCP/IP transmit engine between NUM_REQ segment        |
// |           sources. Latches request pulses, arbitrates (slot 0 strict, the  |
// |           rest round-robin), issues a start pulse, holds the grant until   |
// |           the engine reports end-of-write, then inserts an inter-packet    |
// |           gap. A watchdog aborts a packet that never completes.            |
// | Ports   : clk, rst_n (async, active low)                                   |
// |           bus - tcp_tx_scheduler_if.slave (requests, engine handshake,     |
// |                 grant/status outputs)                                      |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tcp_tx_scheduler
  import tcp_tx_sched_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int IFG_CYCLES     = 12,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic               clk,
  input  logic               rst_n,
  tcp_tx_scheduler_if.slave  bus
);
  localparam int                 c_sel_w    = $clog2(NUM_REQ);
  localparam logic [WDOG_W-1:0]  c_tmo_last = WDOG_W'(TIMEOUT_CYCLES - 1);
  localparam logic [WDOG_W-1:0]  c_gap_last = WDOG_W'(IFG_CYCLES - 1);
  localparam logic [c_sel_w-1:0] c_last_idx = c_sel_w'(NUM_REQ - 1);
  localparam logic [c_sel_w-1:0] c_first_rr = c_sel_w'(1);

  state_t               r_state, w_state_nxt;
  logic [NUM_REQ-1:0]   r_pend, w_pend_nxt, w_clr, w_merge;
  logic [NUM_REQ-1:0]   r_win_oh;
  logic [c_sel_w-1:0]   r_sel, r_ptr, w_ptr_nxt;
  logic [WDOG_W-1:0]    r_cnt, w_cnt_nxt;
  logic [MERGE_W-1:0]   r_merge_cnt;
  logic [3:0]           w_merge_inc;
  logic [NUM_REQ-1:0]   w_pick_oh;
  logic [c_sel_w-1:0]   w_pick_idx;
  logic                 w_pick_valid;
  logic                 w_launch, w_exit, w_timeout, w_active;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .SEL_W   (c_sel_w)
  ) u_rr_pick (
    .i_pend    (r_pend),
    .i_ptr     (r_ptr),
    .o_win_oh  (w_pick_oh),
    .o_win_idx (w_pick_idx),
    .o_valid   (w_pick_valid)
  );

  // Next-state logic; the counter doubles as watchdog and gap timer.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    w_launch    = 1'b0;
    w_exit      = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_valid && !bus.trnsmt_busy_i) begin
          w_launch    = 1'b1;
          w_state_nxt = ST_START;
        end
      end
      ST_START: w_state_nxt = ST_WAIT_END;
      ST_WAIT_END: begin
        // op_end takes precedence over a simultaneous watchdog expiry.
        if (bus.tcp_write_op_end_i) begin
          w_exit = 1'b1;
        end else if (r_cnt == c_tmo_last) begin
          w_exit    = 1'b1;
          w_timeout = 1'b1;
        end
        if (w_exit) begin
          w_state_nxt = (IFG_CYCLES == 0) ? ST_IDLE : ST_GAP;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_GAP: begin
        if (r_cnt == c_gap_last) w_state_nxt = ST_IDLE;
        else                     w_cnt_nxt   = r_cnt + 1'b1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Pending bits: grant clears, flush clears, a same-cycle request always wins.
  always_comb begin
    w_clr       = (r_state == ST_START) ? r_win_oh : '0;
    w_merge     = bus.req_i & r_pend & ~w_clr;
    w_pend_nxt  = (r_pend & ~w_clr & ~{NUM_REQ{bus.flush_i}}) | bus.req_i;
    w_merge_inc = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_merge_inc = w_merge_inc + {3'b000, w_merge[i]};
    end
  end

  assign w_ptr_nxt = (w_pick_idx == c_last_idx) ? c_first_rr : w_pick_idx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend      <= '0;
      r_win_oh    <= '0;
      r_sel       <= '0;
      r_ptr       <= c_first_rr;
      r_cnt       <= '0;
      r_merge_cnt <= '0;
    end else begin
      r_pend      <= w_pend_nxt;
      r_cnt       <= w_cnt_nxt;
      r_merge_cnt <= sat_add8(r_merge_cnt, w_merge_inc);
      if (w_launch) begin
        r_win_oh <= w_pick_oh;
        r_sel    <= w_pick_idx;
        // The strict-priority slot does not advance the round-robin ring.
        if (w_pick_idx != '0) r_ptr <= w_ptr_nxt;
      end
    end
  end

  assign w_active        = (r_state == ST_START) || (r_state == ST_WAIT_END);
  assign bus.start_o     = (r_state == ST_START);
  assign bus.grant_o     = w_active ? r_win_oh : '0;
  assign bus.sel_o       = w_active ? r_sel : '0;
  assign bus.pend_o      = r_pend;
  assign bus.idle_o      = (r_state == ST_IDLE);
  assign bus.timeout_o   = w_timeout;
  assign bus.merge_cnt_o = r_merge_cnt;

endmodule
`default_nettype wire
